control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 35 +++
 rtl/control_unit.sv | 177 +++++++++++++++++
 tb/tb_control_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_pkg.sv
// Shared encodings for the CPU control unit, ALU and datapath:
// opcodes, controller states and bus mux select codes.
package control_unit_pkg;

   localparam int unsigned OP_W     = 5;
   localparam int unsigned REG_W    = 3;
   localparam int unsigned NUM_REGS = 8;
   localparam int unsigned SEL1_W   = 4;
   localparam int unsigned SEL2_W   = 2;

   localparam logic [OP_W-1:0] OP_NOP  = 5'd0;
   localparam logic [OP_W-1:0] OP_ADD  = 5'd1;
   localparam logic [OP_W-1:0] OP_SUB  = 5'd2;
   localparam logic [OP_W-1:0] OP_AND  = 5'd3;
   localparam logic [OP_W-1:0] OP_NOT  = 5'd4;
   localparam logic [OP_W-1:0] OP_RD   = 5'd5;
   localparam logic [OP_W-1:0] OP_WR   = 5'd6;
   localparam logic [OP_W-1:0] OP_BR   = 5'd7;
   localparam logic [OP_W-1:0] OP_BRZ  = 5'd8;
   localparam logic [OP_W-1:0] OP_HALT = 5'd31;

   // bus_1 sources 0-7 are R0-R7; 8 is the program counter
   localparam logic [SEL1_W-1:0] SEL1_PC = 4'd8;

   localparam logic [SEL2_W-1:0] SEL2_ALU  = 2'd0;
   localparam logic [SEL2_W-1:0] SEL2_BUS1 = 2'd1;
   localparam logic [SEL2_W-1:0] SEL2_MEM  = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE, S_FET1, S_FET2, S_DEC,
      S_EX1,  S_RD1,  S_RD2,  S_WR1,
      S_WR2,  S_BR1,  S_BR2,  S_HALT
   } state_e;

endpackage

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetch, decode and execute control
// strobes for a simple 8-register accumulator-style datapath.
module control_unit
   import control_unit_pkg::*;
#(
   parameter int unsigned word_size = 16,
   parameter int unsigned op_size   = 5,
   parameter int unsigned sel1_size = 4,
   parameter int unsigned sel2_size = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [word_size-1:0] instruction,
   input  logic                 Zflag,
   output logic                 load_R0,
   output logic                 load_R1,
   output logic                 load_R2,
   output logic                 load_R3,
   output logic                 load_R4,
   output logic                 load_R5,
   output logic                 load_R6,
   output logic                 load_R7,
   output logic                 load_PC,
   output logic                 inc_PC,
   output logic                 load_IR,
   output logic                 load_add_R,
   output logic                 load_reg_Y,
   output logic                 load_reg_Z,
   output logic [sel1_size-1:0] sel_bus_1_MUX,
   output logic [sel2_size-1:0] sel_bus_2_MUX,
   output logic                 write,
   output logic                 halted,
   output logic                 err
);

   localparam int unsigned SRC_MSB  = word_size - op_size - 1;
   localparam int unsigned DEST_MSB = SRC_MSB - REG_W;
   localparam int unsigned LOW_MSB  = DEST_MSB - REG_W;

   state_e              state_q, state_d;
   logic                err_q;
   logic                illegal;
   logic [OP_W-1:0]     op;
   logic [REG_W-1:0]    src, dest;
   logic [NUM_REGS-1:0] load_r;
   logic [SEL1_W-1:0]   sel1;
   logic [SEL2_W-1:0]   sel2;
   logic                unused_low;

   assign op         = OP_W'(instruction[word_size-1 -: op_size]);
   assign src        = instruction[SRC_MSB -: REG_W];
   assign dest       = instruction[DEST_MSB -: REG_W];
   assign unused_low = ^instruction[LOW_MSB:0];

   // State register; err is sticky until reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_q | illegal;
      end
   end

   // Next-state and control strobes
   always_comb begin
      state_d    = state_q;
      load_r     = '0;
      load_PC    = 1'b0;
      inc_PC     = 1'b0;
      load_IR    = 1'b0;
      load_add_R = 1'b0;
      load_reg_Y = 1'b0;
      load_reg_Z = 1'b0;
      sel1       = '0;
      sel2       = '0;
      write      = 1'b0;
      halted     = 1'b0;
      illegal    = 1'b0;

      case (state_q)
         S_IDLE: if (start) state_d = S_FET1;
         S_FET1: begin
            sel1       = SEL1_PC;
            sel2       = SEL2_BUS1;
            load_add_R = 1'b1;
            state_d    = S_FET2;
         end
         S_FET2: begin
            sel2    = SEL2_MEM;
            load_IR = 1'b1;
            inc_PC  = 1'b1;
            state_d = S_DEC;
         end
         S_DEC: begin
            case (op)
               OP_NOP: state_d = S_FET1;
               OP_ADD, OP_SUB, OP_AND: begin
                  sel1       = SEL1_W'(src);
                  sel2       = SEL2_BUS1;
                  load_reg_Y = 1'b1;
                  state_d    = S_EX1;
               end
               OP_NOT: begin
                  sel1         = SEL1_W'(src);
                  sel2         = SEL2_ALU;
                  load_reg_Z   = 1'b1;
                  load_r[dest] = 1'b1;
                  state_d      = S_FET1;
               end
               OP_RD, OP_WR, OP_BR, OP_BRZ: begin
                  // untaken BRZ steps the PC over its target operand word
                  if (op != OP_BRZ || Zflag) begin
                     sel1       = SEL1_PC;
                     sel2       = SEL2_BUS1;
                     load_add_R = 1'b1;
                     state_d    = (op == OP_RD) ? S_RD1 :
                                  (op == OP_WR) ? S_WR1 : S_BR1;
                  end else begin
                     inc_PC  = 1'b1;
                     state_d = S_FET1;
                  end
               end
               OP_HALT: state_d = S_HALT;
               default: begin
                  illegal = 1'b1;
                  state_d = S_HALT;
               end
            endcase
         end
         S_EX1: begin
            sel1         = SEL1_W'(dest);
            sel2         = SEL2_ALU;
            load_reg_Z   = 1'b1;
            load_r[dest] = 1'b1;
            state_d      = S_FET1;
         end
         S_RD1, S_WR1: begin
            sel2       = SEL2_MEM;
            load_add_R = 1'b1;
            inc_PC     = 1'b1;
            state_d    = (state_q == S_RD1) ? S_RD2 : S_WR2;
         end
         S_RD2: begin
            sel2         = SEL2_MEM;
            load_r[dest] = 1'b1;
            state_d      = S_FET1;
         end
         S_WR2: begin
            sel1    = SEL1_W'(src);
            write   = 1'b1;
            state_d = S_FET1;
         end
         S_BR1: begin
            sel2       = SEL2_MEM;
            load_add_R = 1'b1;
            state_d    = S_BR2;
         end
         S_BR2: begin
            sel2    = SEL2_MEM;
            load_PC = 1'b1;
            state_d = S_FET1;
         end
         S_HALT: halted = 1'b1;
         default: state_d = S_IDLE;
      endcase
   end

   assign {load_R7, load_R6, load_R5, load_R4,
           load_R3, load_R2, load_R1, load_R0} = load_r;
   assign sel_bus_1_MUX = sel1_size'(sel1);
   assign sel_bus_2_MUX = sel2_size'(sel2);
   assign err           = err_q | illegal;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction-level reference model
// with randomized programs plus directed literal checks.
module tb_control_unit;

   typedef struct packed {
      logic [7:0] ld_r;
      logic       ld_pc, inc_pc, ld_ir, ld_add, ld_y, ld_z;
      logic [3:0] s1;
      logic [1:0] s2;
      logic       wr, hlt, er;
   } outs_t;

   logic        clk = 1'b0;
   logic        rst, start, Zflag;
   logic [15:0] instruction;
   logic        load_R0, load_R1, load_R2, load_R3, load_R4, load_R5, load_R6, load_R7;
   logic        load_PC, inc_PC, load_IR, load_add_R, load_reg_Y, load_reg_Z;
   logic [3:0]  sel_bus_1_MUX;
   logic [1:0]  sel_bus_2_MUX;
   logic        write, halted, err;

   int    checks   = 0;
   int    failures = 0;
   logic  m_err    = 1'b0;
   outs_t exp_q[$];
   outs_t seen[$];

   control_unit dut (
      .clk(clk), .rst(rst), .start(start), .instruction(instruction), .Zflag(Zflag),
      .load_R0(load_R0), .load_R1(load_R1), .load_R2(load_R2), .load_R3(load_R3),
      .load_R4(load_R4), .load_R5(load_R5), .load_R6(load_R6), .load_R7(load_R7),
      .load_PC(load_PC), .inc_PC(inc_PC), .load_IR(load_IR), .load_add_R(load_add_R),
      .load_reg_Y(load_reg_Y), .load_reg_Z(load_reg_Z),
      .sel_bus_1_MUX(sel_bus_1_MUX), .sel_bus_2_MUX(sel_bus_2_MUX),
      .write(write), .halted(halted), .err(err)
   );

   always #5 clk = ~clk;

   function automatic outs_t dut_outs();
      outs_t o;
      o.ld_r   = {load_R7, load_R6, load_R5, load_R4, load_R3, load_R2, load_R1, load_R0};
      o.ld_pc  = load_PC;
      o.inc_pc = inc_PC;
      o.ld_ir  = load_IR;
      o.ld_add = load_add_R;
      o.ld_y   = load_reg_Y;
      o.ld_z   = load_reg_Z;
      o.s1     = sel_bus_1_MUX;
      o.s2     = sel_bus_2_MUX;
      o.wr     = write;
      o.hlt    = halted;
      o.er     = err;
      return o;
   endfunction

   function automatic outs_t base();
      outs_t o = '0;
      o.er = m_err;
      return o;
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   // Per-cycle comparison against the model's expected outputs
   always @(negedge clk) begin
      outs_t e, g;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = dut_outs();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL cycle_outputs t=%0t got=%06h expected=%06h", $time, g, e);
         end
      end
   end

   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // One clock cycle: drive inputs after the edge, queue the expected outputs
   task automatic cyc(input logic [15:0] ins, input logic z, input logic st, input outs_t e);
      @(posedge clk);
      #1;
      instruction = ins;
      Zflag       = z;
      start       = st;
      exp_q.push_back(e);
      #1;
      seen.push_back(dut_outs());
   endtask

   task automatic idle_then_start(input int n);
      for (int i = 0; i < n; i++) cyc(16'($urandom), rb(), 1'b0, base());
      cyc(16'($urandom), rb(), 1'b1, base());
   endtask

   // Expected cycle-by-cycle behaviour of one whole instruction
   task automatic run_instr(input logic [15:0] ins, input int zmode);
      outs_t      o;
      logic [4:0] op;
      logic [2:0] s, d;
      logic       z;
      op = ins[15:11];
      s  = ins[10:8];
      d  = ins[7:5];
      seen.delete();
      o = base(); o.s1 = 4'd8; o.s2 = 2'd1; o.ld_add = 1'b1;
      cyc(ins, rb(), rb(), o);
      o = base(); o.s2 = 2'd2; o.ld_ir = 1'b1; o.inc_pc = 1'b1;
      cyc(ins, rb(), rb(), o);
      z = (zmode == 2) ? rb() : 1'(zmode);
      o = base();
      if (op >= 5'd1 && op <= 5'd3) begin
         o.s1 = {1'b0, s}; o.s2 = 2'd1; o.ld_y = 1'b1;
         cyc(ins, z, rb(), o);
         o = base(); o.s1 = {1'b0, d}; o.s2 = 2'd0; o.ld_z = 1'b1; o.ld_r = 8'd1 << d;
         cyc(ins, rb(), rb(), o);
      end else if (op == 5'd4) begin
         o.s1 = {1'b0, s}; o.s2 = 2'd0; o.ld_z = 1'b1; o.ld_r = 8'd1 << d;
         cyc(ins, z, rb(), o);
      end else if ((op >= 5'd5 && op <= 5'd7) || (op == 5'd8 && z)) begin
         o.s1 = 4'd8; o.s2 = 2'd1; o.ld_add = 1'b1;
         cyc(ins, z, rb(), o);
         o = base(); o.s2 = 2'd2; o.ld_add = 1'b1; o.inc_pc = (op == 5'd5 || op == 5'd6);
         cyc(ins, rb(), rb(), o);
         o = base();
         if (op == 5'd5) begin
            o.s2 = 2'd2; o.ld_r = 8'd1 << d;
         end else if (op == 5'd6) begin
            o.s1 = {1'b0, s}; o.wr = 1'b1;
         end else begin
            o.s2 = 2'd2; o.ld_pc = 1'b1;
         end
         cyc(ins, rb(), rb(), o);
      end else if (op == 5'd8) begin
         o.inc_pc = 1'b1;
         cyc(ins, z, rb(), o);
      end else if (op == 5'd0 || op == 5'd31) begin
         cyc(ins, z, rb(), o);
      end else begin
         m_err = 1'b1;
         cyc(ins, z, rb(), base());
      end
   endtask

   task automatic halt_cycles(input int n);
      outs_t o;
      o = base(); o.hlt = 1'b1;
      for (int i = 0; i < n; i++) cyc(16'($urandom), rb(), rb(), o);
   endtask

   // Asynchronous reset in the middle of a cycle with nothing queued
   task automatic async_reset(input string tag);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      m_err = 1'b0;
      lit(tag, 32'(dut_outs()), 32'd0);
      cyc(16'($urandom), rb(), 1'b1, base());
      rst   = 1'b1;
      start = 1'b0;
   endtask

   initial begin
      logic [15:0] ins;
      rst = 1'b0; start = 1'b0; Zflag = 1'b0; instruction = 16'h0000;
      #2;
      lit("reset_state", 32'(dut_outs()), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      idle_then_start(3);

      run_instr(16'h0940, 2);
      lit("fet1_pattern", 32'({seen[0].s1, seen[0].s2, seen[0].ld_add}), 32'({4'd8, 2'd1, 1'b1}));
      lit("fet2_pattern", 32'({seen[1].ld_ir, seen[1].inc_pc}), 32'(2'b11));
      lit("add_dec", 32'({seen[2].ld_y, seen[2].s1}), 32'({1'b1, 4'd1}));
      lit("add_ex1", 32'({seen[3].ld_r, seen[3].s1, seen[3].s2, seen[3].ld_z}),
          32'({8'h04, 4'd2, 2'd0, 1'b1}));
      lit("add_cycles", 32'(seen.size()), 32'd4);

      run_instr(16'h2860, 2);
      lit("rd2_load_r3", 32'({seen[4].ld_r, seen[4].s2}), 32'({8'h08, 2'd2}));
      run_instr(16'h3400, 2);
      lit("wr2_write", 32'({seen[4].wr, seen[4].s1}), 32'({1'b1, 4'd4}));
      run_instr(16'h4000, 0);
      lit("brz_nt_dec", 32'({seen[2].inc_pc, seen[2].ld_pc}), 32'(2'b10));
      lit("brz_nt_cycles", 32'(seen.size()), 32'd3);
      run_instr(16'h4000, 1);
      lit("brz_t_br2", 32'(seen[4].ld_pc), 32'd1);

      for (int i = 0; i < 150; i++) begin
         ins = {5'($urandom_range(0, 8)), 11'($urandom)};
         run_instr(ins, 2);
      end

      run_instr(16'hF800 | 16'($urandom_range(0, 16'h07FF)), 2);
      halt_cycles(6);
      lit("halt_hold", 32'({seen[seen.size()-1].hlt, seen[seen.size()-1].er}), 32'(2'b10));

      async_reset("reset_from_halt");
      idle_then_start(2);
      for (int i = 0; i < 5; i++) run_instr({5'($urandom_range(0, 8)), 11'($urandom)}, 2);
      run_instr(16'h5000, 2);
      halt_cycles(5);
      lit("illegal_halt", 32'({seen[seen.size()-1].hlt, seen[seen.size()-1].er}), 32'(2'b11));

      async_reset("reset_clears_err");
      idle_then_start(2);

      // Abort an ADD in its execute cycle
      seen.delete();
      begin
         outs_t o;
         o = base(); o.s1 = 4'd8; o.s2 = 2'd1; o.ld_add = 1'b1;
         cyc(16'h0940, rb(), 1'b0, o);
         o = base(); o.s2 = 2'd2; o.ld_ir = 1'b1; o.inc_pc = 1'b1;
         cyc(16'h0940, rb(), 1'b0, o);
         o = base(); o.s1 = 4'd1; o.s2 = 2'd1; o.ld_y = 1'b1;
         cyc(16'h0940, rb(), 1'b0, o);
      end
      @(posedge clk);
      #2;
      lit("ex1_before_reset", 32'({load_R2, load_reg_Z}), 32'(2'b11));
      rst = 1'b0;
      #1;
      lit("ex1_async_reset", 32'(dut_outs()), 32'd0);
      cyc(16'h0940, rb(), 1'b0, base());
      rst = 1'b1;
      for (int i = 0; i < 4; i++) cyc(16'($urandom), rb(), 1'b0, base());
      cyc(16'h0000, rb(), 1'b1, base());
      run_instr(16'h0000, 2);

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
